// File: rtl/arb4_pkg.sv
// Shared types and constants for the 4-way round-robin grant arbiter.
package arb4_pkg;

    localparam int N_REQ = 4;
    localparam int CNT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    function automatic logic [1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) idx = i[1:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb4_rr_x1_rr_pick4.sv
// Round-robin picker: one-hot first set request at or after start, wrapping.
// Latency: purely combinational. Backpressure: none, pure function of inputs.
module rr_pick4
    import arb4_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       start,
    output logic [N_REQ-1:0] win
);

    logic       found;
    logic [1:0] idx;

    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 2'd0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = start + i[1:0];
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb4_rr_x1.sv
// Four-requester round-robin arbiter with bounded hold time and registered one-hot grant.
// Latency: one cycle from request to grant. Backpressure: requests are levels, never latched.
module arb4_rr_x1
    import arb4_pkg::*;
#(
    parameter int HOLD_MAX = 4
) (
    input  logic       CK,
    input  logic       RST,
    input  logic       A1,
    input  logic       A2,
    input  logic       A3,
    input  logic       A4,
    output logic [3:0] G,
    output logic       ZN
);

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

    state_t             state;
    logic [N_REQ-1:0]   g_q;
    logic               zn_q;
    logic [1:0]         ptr;
    logic [CNT_W-1:0]   cnt;

    logic [N_REQ-1:0]   req;
    logic [N_REQ-1:0]   pick;
    logic               owner_req;
    logic               do_grant;
    logic               go_idle;
    logic               do_inc;

    assign req       = {A4, A3, A2, A1};
    assign owner_req = |(req & g_q);

    // Excluding the owner lets one picker serve every case: in IDLE g_q is zero,
    // and when the owner drops its bit is already clear.
    rr_pick4 u_pick (
        .req   (req & ~g_q),
        .start (ptr),
        .win   (pick)
    );

    always_comb begin
        do_grant = 1'b0;
        go_idle  = 1'b0;
        do_inc   = 1'b0;
        if (state == IDLE) begin
            do_grant = |pick;
        end else if (!owner_req) begin
            do_grant = |pick;
            go_idle  = ~(|pick);
        end else if (cnt < HOLD_LIM) begin
            do_inc = 1'b1;
        end else begin
            do_grant = |pick;
        end
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            g_q   <= '0;
            zn_q  <= 1'b0;
            ptr   <= 2'd0;
            cnt   <= '0;
        end else if (do_grant) begin
            state <= OWN;
            g_q   <= pick;
            zn_q  <= 1'b1;
            ptr   <= onehot_to_idx(pick) + 2'd1;
            cnt   <= CNT_W'(1);
        end else if (go_idle) begin
            state <= IDLE;
            g_q   <= '0;
            zn_q  <= 1'b0;
            cnt   <= '0;
        end else if (do_inc) begin
            cnt   <= cnt + CNT_W'(1);
        end
    end

    assign G  = g_q;
    assign ZN = zn_q;

endmodule

// File: tb/tb_arb4_rr_x1.sv
// Bench for arb4_rr_x1: directed scenarios plus random requests against a cycle-level reference model.
module tb_arb4_rr_x1;

    localparam int HOLD = 4;

    logic       CK = 1'b0;
    logic       RST;
    logic       A1, A2, A3, A4;
    logic [3:0] G;
    logic       ZN;

    int checks = 0;
    int errors = 0;

    int m_owner;
    int m_cnt;
    int m_ptr;

    always #5 CK = ~CK;

    arb4_rr_x1 #(.HOLD_MAX(HOLD)) dut (
        .CK  (CK),
        .RST (RST),
        .A1  (A1),
        .A2  (A2),
        .A3  (A3),
        .A4  (A4),
        .G   (G),
        .ZN  (ZN)
    );

    task automatic chk(input string tag, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int first_pending(input logic [3:0] r, input int start, input int skip);
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (start + k) % 4;
            if (j != skip && r[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_ptr   = 0;
    endtask

    task automatic model_step(input logic [3:0] r);
        int w;
        w = -1;
        if (m_owner < 0 || !r[m_owner]) begin
            w = first_pending(r, m_ptr, -1);
            if (w < 0) begin
                m_owner = -1;
                m_cnt   = 0;
            end
        end else if (m_cnt < HOLD) begin
            m_cnt++;
        end else begin
            w = first_pending(r, m_ptr, m_owner);
        end
        if (w >= 0) begin
            m_owner = w;
            m_cnt   = 1;
            m_ptr   = (w + 1) % 4;
        end
    endtask

    function automatic logic [3:0] exp_g();
        return (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    endfunction

    task automatic set_req(input logic [3:0] r);
        {A4, A3, A2, A1} = r;
    endtask

    // Drive requests just after a falling edge, then check after the next falling edge.
    task automatic cycle(input logic [3:0] r, input string tag);
        logic [3:0] e;
        set_req(r);
        model_step(r);
        @(negedge CK);
        e = exp_g();
        chk({tag, "_g"}, G, e);
        chk({tag, "_zn"}, {3'b000, ZN}, {3'b000, |e});
        chk({tag, "_onehot"}, {3'b000, $onehot0(G)}, 4'b0001);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        set_req(4'b0000);
        #1;
        chk("rst_async_g", G, 4'b0000);
        chk("rst_async_zn", {3'b000, ZN}, 4'b0000);
        @(negedge CK);
        @(negedge CK);
        chk("rst_hold_g", G, 4'b0000);
        chk("rst_hold_zn", {3'b000, ZN}, 4'b0000);
        RST = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [3:0] r;
        model_reset();
        set_req(4'b0000);
        do_reset();

        // Idle with no requests
        for (int i = 0; i < 5; i++) cycle(4'b0000, "idle");

        // Single requester A3
        cycle(4'b0100, "a3_on");
        chk("a3_on_const", G, 4'b0100);
        cycle(4'b0000, "a3_off");
        chk("a3_off_const", G, 4'b0000);

        // All requesting: rotation every HOLD cycles
        do_reset();
        for (int i = 0; i < 17; i++) begin
            cycle(4'b1111, "rr_all");
            chk("rr_tab", G, 4'(1 << ((i / 4) % 4)));
        end

        // A2 alone saturates, then A4 appears
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(4'b0010, "a2_alone");
            chk("a2_alone_const", G, 4'b0010);
        end
        cycle(4'b1010, "a4_join");
        chk("a4_join_const", G, 4'b1000);

        // Owner drops with another pending: no bubble
        do_reset();
        cycle(4'b0001, "a1_own");
        cycle(4'b0101, "a3_wait");
        chk("a3_wait_const", G, 4'b0001);
        cycle(4'b0100, "handoff");
        chk("handoff_const", G, 4'b0100);

        // Asynchronous reset mid-grant
        do_reset();
        cycle(4'b0010, "pre_arst");
        chk("pre_arst_const", G, 4'b0010);
        #2;
        RST = 1'b1;
        #1;
        chk("arst_g", G, 4'b0000);
        chk("arst_zn", {3'b000, ZN}, 4'b0000);
        model_reset();
        @(negedge CK);
        RST = 1'b0;
        cycle(4'b1111, "post_arst");
        chk("post_arst_const", G, 4'b0001);

        // Random traffic with sticky requests and occasional async reset
        r = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            else if ($urandom_range(0, 5) == 0) r[$urandom_range(0, 3)] = ~r[$urandom_range(0, 3)];
            if ($urandom_range(0, 99) == 0) begin
                #($urandom_range(1, 4));
                RST = 1'b1;
                #1;
                chk("rnd_arst_g", G, 4'b0000);
                model_reset();
                @(negedge CK);
                RST = 1'b0;
            end
            cycle(r, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
